vga_tile_renderer: RTL and testbench
====================================

Name: vga_tile_renderer

Overview:
Pipelined, parametrised successor to the combinational tile/sprite drawer. It takes a sequential pixel stream (row/col plus strobes) from the VGA timing block and looks up tile codes from an external tile-map RAM. Codes are translated through a writable palette, horizontal scroll is applied, and up to NUM_SPRITES box sprites are composited with fixed priority. Output is registered RGB444 at a fixed latency, ready for the VGA output pins.

Parameters:
TILE_LOG2, 5, tile edge = 2**TILE_LOG2 pixels (power of two; replaces divide-by-BLOCK_WIDTH).
MAP_COLS, 32, tile-map width in tiles (world wraps horizontally).
MAP_ROWS, 15, tile-map height in tiles.
CODE_W, 4, tile-code width; palette depth = 2**CODE_W.
NUM_SPRITES, 4, sprite channels.
SPRITE_SIZE, 42, sprite box edge in pixels.
COORD_W, 10, width of row/col/scroll/sprite coordinates.

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
pix_valid  in  1  row/col is an active-video pixel this cycle
frame_start  in  1  high with the first pixel of a frame; latches scroll and sprite state
row  in  COORD_W  screen row
col  in  COORD_W  screen column
scroll_x  in  COORD_W  horizontal world offset in pixels, < MAP_COLS<<TILE_LOG2
map_addr  out  clog2(MAP_ROWS*MAP_COLS)  tile-map RAM address, row-major (tile_row*MAP_COLS + tile_col)
map_data  in  CODE_W  tile code; 1-cycle synchronous read latency
pal_we  in  1  palette write enable
pal_addr  in  CODE_W  palette write index
pal_data  in  12  {R,G,B} 4 bits each
sprite_en  in  NUM_SPRITES  per-sprite enable
sprite_x  in  NUM_SPRITES*COORD_W  packed sprite left edges, sprite 0 in the LSBs
sprite_y  in  NUM_SPRITES*COORD_W  packed sprite top edges
sprite_rgb  in  NUM_SPRITES*12  packed sprite colours
out_valid  out  1  RGB corresponds to an active pixel
red, green, blue  out  4 each  registered colour

Behaviour:
- Reset (synchronous, active-high): out_valid=0, red/green/blue=0, map_addr=0, all pipeline valids=0, latched scroll=0, latched sprite_en=0.
- Palette reset contents: 0=000, 1=09F, 2=843, 3=0F2, 4=09F, 5=000; all other entries 000.
- Reset asserted mid-frame: the pipeline flushes immediately. No valid output appears until a new pix_valid is accepted after reset deasserts.
- Frame latch: when frame_start & pix_valid, the block captures scroll_x, sprite_en, sprite_x, sprite_y and sprite_rgb into shadow registers. That same pixel already uses the new values. Input changes between frame_start pulses have no effect.
- S0 (accept):
  - wx = col + scroll_lat, width COORD_W+1; if wx >= MAP_COLS<<TILE_LOG2, subtract it once.
  - tile_col = wx>>TILE_LOG2; tile_row = row>>TILE_LOG2.
  - oob = tile_row >= MAP_ROWS.
  - map_addr is registered from these (0 when oob).
  - Sprite hit i = sprite_en_lat[i] & x_i <= col < x_i+SPRITE_SIZE & y_i <= row < y_i+SPRITE_SIZE. Bounds are half-open; compare at COORD_W+1 bits so there is no wrap.
  - Lowest-index hit wins; the winner's rgb and a hit flag are registered.
- S1 (map read): map_data is valid this cycle; hit/rgb/oob/valid are delayed one stage.
- S2 (palette): colour = pal[oob ? 0 : map_data]. If hit, colour = winning sprite_rgb. The result is registered to red/green/blue with out_valid.
- Latency: fixed 3 cycles from pix_valid to out_valid.
- pix_valid=0 is a bubble: out_valid=0 three cycles later and RGB forced to 0 (blanking). Throughput is 1 pixel/cycle with no stalls.
- Palette write timing: takes effect the cycle after pal_we. A lookup of the same entry in the write cycle returns the old value.
- Palette write priority: a write during reset is ignored, because reset wins.
- Scroll wrap: world column MAP_COLS<<TILE_LOG2 maps to tile_col 0. scroll_x out of range is undefined input; the single subtract is the only correction.
- Sprites partially off-screen need no special case. Pixels beyond SCREEN bounds are simply never presented.

Test Plan:
- Reset then one frame with all map_data=1, no sprites -> every out_valid pixel 0,9,F; out_valid lags pix_valid by exactly 3 cycles; bubbles give RGB 000.
- Defaults TILE_LOG2=5, MAP_COLS=32, scroll_x=1000 latched: col=23 -> wx 1023 -> tile_col 31. col=24 -> wx 1024 wraps to 0 -> tile_col 0, map_addr=row_tile*32+0.
- Sprites 0 and 2 both enabled at x=100, y=100 (rgb F00 and 00F): pixel (100,100) -> F00. Pixel (141,141) -> F00. Pixel (142,100) -> tile colour. Disable sprite 0 -> (100,100) gives 00F.
- Change scroll_x and sprite_x mid-frame (no frame_start) -> output unchanged until the next frame_start pixel, which uses the new values.
- pal_we to entry 3 = 123 while streaming code-3 tiles -> pixels looked up before and in the write cycle show 0F2, later pixels show 123; row 480 (tile_row 15 >= MAP_ROWS) shows entry 0.
- Assert reset for 1 cycle mid-line with valid pixels in flight -> out_valid=0 and RGB=0 for the next 3 cycles, latched sprites disabled, palette restored to defaults.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// Pipelined tile/sprite renderer: tile-map lookup, palette, horizontal scroll and
// fixed-priority box sprites, producing registered RGB444 three cycles after each pixel.
module vga_tile_renderer #(
    parameter int TILE_LOG2   = 5,
    parameter int MAP_COLS    = 32,
    parameter int MAP_ROWS    = 15,
    parameter int CODE_W      = 4,
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 42,
    parameter int COORD_W     = 10
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     pix_valid,
    input  logic                                     frame_start,
    input  logic [COORD_W-1:0]                       row,
    input  logic [COORD_W-1:0]                       col,
    input  logic [COORD_W-1:0]                       scroll_x,
    output logic [$clog2(MAP_ROWS*MAP_COLS)-1:0]     map_addr,
    input  logic [CODE_W-1:0]                        map_data,
    input  logic                                     pal_we,
    input  logic [CODE_W-1:0]                        pal_addr,
    input  logic [11:0]                              pal_data,
    input  logic [NUM_SPRITES-1:0]                   sprite_en,
    input  logic [NUM_SPRITES*COORD_W-1:0]           sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]           sprite_y,
    input  logic [NUM_SPRITES*12-1:0]                sprite_rgb,
    output logic                                     out_valid,
    output logic [3:0]                               red,
    output logic [3:0]                               green,
    output logic [3:0]                               blue
);

    localparam int ADDR_W = $clog2(MAP_ROWS*MAP_COLS);
    localparam int TR_W   = COORD_W - TILE_LOG2;
    localparam int TC_W   = COORD_W + 1 - TILE_LOG2;
    localparam int PAL_N  = 2**CODE_W;
    localparam logic [COORD_W:0] WORLD_W  = (COORD_W+1)'(MAP_COLS << TILE_LOG2);
    localparam logic [TR_W-1:0]  ROWS_LIM = TR_W'(MAP_ROWS);
    localparam logic [COORD_W:0] BOX      = (COORD_W+1)'(SPRITE_SIZE);

    function automatic logic [11:0] pal_default(input int idx);
        case (idx)
            1:       pal_default = 12'h09F;
            2:       pal_default = 12'h843;
            3:       pal_default = 12'h0F2;
            4:       pal_default = 12'h09F;
            default: pal_default = 12'h000;
        endcase
    endfunction

    logic [COORD_W-1:0]             scroll_lat;
    logic [NUM_SPRITES-1:0]         en_lat;
    logic [NUM_SPRITES*COORD_W-1:0] x_lat, y_lat;
    logic [NUM_SPRITES*12-1:0]      rgb_lat;

    // The frame_start pixel must already see the new frame state, so bypass the shadows.
    logic                           latch_now;
    logic [COORD_W-1:0]             scroll_eff;
    logic [NUM_SPRITES-1:0]         en_eff;
    logic [NUM_SPRITES*COORD_W-1:0] x_eff, y_eff;
    logic [NUM_SPRITES*12-1:0]      rgb_eff;

    assign latch_now  = frame_start & pix_valid;
    assign scroll_eff = latch_now ? scroll_x   : scroll_lat;
    assign en_eff     = latch_now ? sprite_en  : en_lat;
    assign x_eff      = latch_now ? sprite_x   : x_lat;
    assign y_eff      = latch_now ? sprite_y   : y_lat;
    assign rgb_eff    = latch_now ? sprite_rgb : rgb_lat;

    logic [COORD_W:0]  wx_sum, wx, cx, cy;
    logic [TC_W-1:0]   tile_col;
    logic [TR_W-1:0]   tile_row;
    logic              oob0;
    logic [ADDR_W-1:0] addr0;

    assign wx_sum   = {1'b0, col} + {1'b0, scroll_eff};
    assign wx       = (wx_sum >= WORLD_W) ? wx_sum - WORLD_W : wx_sum;
    assign tile_col = wx[COORD_W:TILE_LOG2];
    assign tile_row = row[COORD_W-1:TILE_LOG2];
    assign oob0     = tile_row >= ROWS_LIM;
    assign addr0    = ADDR_W'(tile_row) * ADDR_W'(MAP_COLS) + ADDR_W'(tile_col);
    assign cx       = {1'b0, col};
    assign cy       = {1'b0, row};

    logic             hit0;
    logic [11:0]      rgb0;
    logic [COORD_W:0] sx, sy;

    // Scan from the highest index down so the lowest-index hit is left standing.
    always_comb begin
        hit0 = 1'b0;
        rgb0 = 12'h000;
        sx   = '0;
        sy   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            sx = {1'b0, x_eff[i*COORD_W +: COORD_W]};
            sy = {1'b0, y_eff[i*COORD_W +: COORD_W]};
            if (en_eff[i] && cx >= sx && cx < sx + BOX && cy >= sy && cy < sy + BOX) begin
                hit0 = 1'b1;
                rgb0 = rgb_eff[i*12 +: 12];
            end
        end
    end

    logic        v1, hit1, oob1;
    logic [11:0] rgb1;
    logic        v2, hit2, oob2;
    logic [11:0] rgb2;
    logic [11:0] pal [PAL_N];
    logic [11:0] pal_rd;

    assign pal_rd = pal[oob2 ? CODE_W'(0) : map_data];

    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_lat <= '0;
            en_lat     <= '0;
            x_lat      <= '0;
            y_lat      <= '0;
            rgb_lat    <= '0;
            map_addr   <= '0;
            v1         <= 1'b0;
            hit1       <= 1'b0;
            oob1       <= 1'b0;
            rgb1       <= 12'h000;
            v2         <= 1'b0;
            hit2       <= 1'b0;
            oob2       <= 1'b0;
            rgb2       <= 12'h000;
            out_valid  <= 1'b0;
            red        <= 4'h0;
            green      <= 4'h0;
            blue       <= 4'h0;
            for (int i = 0; i < PAL_N; i++) pal[i] <= pal_default(i);
        end else begin
            if (latch_now) begin
                scroll_lat <= scroll_x;
                en_lat     <= sprite_en;
                x_lat      <= sprite_x;
                y_lat      <= sprite_y;
                rgb_lat    <= sprite_rgb;
            end
            if (pal_we) pal[pal_addr] <= pal_data;

            map_addr <= oob0 ? '0 : addr0;
            v1       <= pix_valid;
            hit1     <= hit0;
            oob1     <= oob0;
            rgb1     <= rgb0;

            v2       <= v1;
            hit2     <= hit1;
            oob2     <= oob1;
            rgb2     <= rgb1;

            out_valid <= v2;
            {red, green, blue} <= v2 ? (hit2 ? rgb2 : pal_rd) : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer: behavioural pixel model checked every cycle,
// plus literal probes for scroll wrap, sprite priority, palette timing and reset.
module tb_vga_tile_renderer;

    localparam int CW = 10;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid, frame_start;
    logic [CW-1:0] row, col, scroll_x;
    logic [8:0]    map_addr;
    logic [3:0]    map_data;
    logic          pal_we;
    logic [3:0]    pal_addr;
    logic [11:0]   pal_data;
    logic [NS-1:0] sprite_en;
    logic [NS*CW-1:0] sprite_x, sprite_y;
    logic [NS*12-1:0] sprite_rgb;
    logic          out_valid;
    logic [3:0]    red, green, blue;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .frame_start(frame_start),
        .row(row), .col(col), .scroll_x(scroll_x), .map_addr(map_addr), .map_data(map_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_rgb(sprite_rgb),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue)
    );

    // External tile-map RAM with one cycle of read latency
    logic [3:0] map_mem [512];
    always @(posedge clk) map_data <= map_mem[map_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pal_def(input int i);
        case (i)
            1, 4:    pal_def = 12'h09F;
            2:       pal_def = 12'h843;
            3:       pal_def = 12'h0F2;
            default: pal_def = 12'h000;
        endcase
    endfunction

    // Model: each accepted pixel resolves to either a sprite colour or a palette index;
    // the palette itself is read two clocks later, when the colour is registered.
    logic [11:0] pal_m [16];
    int          lat_scroll = 0;
    logic [3:0]  lat_en = '0;
    int          lat_x [NS];
    int          lat_y [NS];
    logic [11:0] lat_rgb [NS];
    logic        d1_v = 0, d1_hit = 0, d2_v = 0, d2_hit = 0;
    logic [11:0] d1_rgb = 0, d2_rgb = 0;
    logic [3:0]  d1_idx = 0, d2_idx = 0;
    logic        exp_v = 0, addr_chk = 0, model_on = 0;
    logic [11:0] exp_rgb = 0;
    int          exp_addr = 0;
    int          m_r, m_c, m_wx, m_tr, m_tc, m_addr;
    logic        m_hit, m_oob;
    logic [11:0] m_rgb;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_v = 0; exp_rgb = 0; d1_v = 0; d2_v = 0;
                lat_scroll = 0; lat_en = '0;
                for (int i = 0; i < 16; i++) pal_m[i] = pal_def(i);
                exp_addr = 0; addr_chk = 1;
            end else begin
                exp_v   = d2_v;
                exp_rgb = d2_v ? (d2_hit ? d2_rgb : pal_m[d2_idx]) : 12'h000;
                d2_v = d1_v; d2_hit = d1_hit; d2_rgb = d1_rgb; d2_idx = d1_idx;
                if (pix_valid) begin
                    if (frame_start) begin
                        lat_scroll = int'(scroll_x);
                        lat_en = sprite_en;
                        for (int i = 0; i < NS; i++) begin
                            lat_x[i]   = int'(sprite_x[i*CW +: CW]);
                            lat_y[i]   = int'(sprite_y[i*CW +: CW]);
                            lat_rgb[i] = sprite_rgb[i*12 +: 12];
                        end
                    end
                    m_r  = int'(row);
                    m_c  = int'(col);
                    m_wx = (m_c + lat_scroll) % 1024;
                    m_tr = m_r / 32;
                    m_tc = m_wx / 32;
                    m_oob  = (m_tr >= 15);
                    m_addr = m_oob ? 0 : m_tr * 32 + m_tc;
                    m_hit = 0; m_rgb = 0;
                    for (int i = 0; i < NS; i++)
                        if (!m_hit && lat_en[i] && m_c >= lat_x[i] && m_c < lat_x[i] + 42 &&
                            m_r >= lat_y[i] && m_r < lat_y[i] + 42) begin
                            m_hit = 1; m_rgb = lat_rgb[i];
                        end
                    d1_v = 1; d1_hit = m_hit; d1_rgb = m_rgb;
                    d1_idx = m_oob ? 4'd0 : map_mem[m_addr];
                    exp_addr = m_addr; addr_chk = 1;
                end else begin
                    d1_v = 0; addr_chk = 0;
                end
                if (pal_we) pal_m[pal_addr] = pal_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("out_valid", 32'(out_valid), 32'(exp_v));
                check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
                if (addr_chk) check("map_addr", 32'(map_addr), 32'(exp_addr));
            end
        end
    end

    task automatic cyc(input logic v, input logic fs, input int r, input int c);
        @(posedge clk);
        #1;
        pix_valid = v; frame_start = fs;
        row = CW'(r); col = CW'(c);
        pal_we = 0; reset = 0;
    endtask

    task automatic probe(input string name, input int r, input int c, input logic fs,
                         input logic [11:0] exp);
        cyc(1, fs, r, c);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(posedge clk);
        #1;
        check(name, 32'({out_valid, red, green, blue}), 32'({1'b1, exp}));
    endtask

    initial begin
        reset = 1; pix_valid = 0; frame_start = 0; row = 0; col = 0; scroll_x = 0;
        pal_we = 0; pal_addr = 0; pal_data = 0;
        sprite_en = 0; sprite_x = 0; sprite_y = 0; sprite_rgb = 0;
        for (int i = 0; i < 512; i++) map_mem[i] = 4'd1;
        map_mem[6*32+8] = 4'd5;
        for (int i = 64; i < 96; i++) map_mem[i] = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        model_on = 1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_rgb", 32'({red, green, blue}), 0);
        check("reset_map_addr", 32'(map_addr), 0);

        // All-code-1 line with scattered bubbles
        cyc(1, 1, 0, 0);
        for (int c = 1; c < 64; c++) cyc((c % 7) != 3, 0, 0, c);
        probe("tile_code1", 5, 5, 0, 12'h09F);

        // Horizontal scroll wrap at world column 1024
        map_mem[31] = 4'd2;
        map_mem[0]  = 4'd3;
        scroll_x = 10'd1000;
        probe("wrap_col23", 0, 23, 1, 12'h843);
        probe("wrap_col24", 0, 24, 0, 12'h0F2);
        cyc(1, 0, 40, 24);
        cyc(0, 0, 0, 0);
        check("addr_wrap", 32'(map_addr), 32);
        for (int c = 16; c < 40; c++) cyc(1, 0, 33, c);

        // Sprite priority and half-open box bounds
        scroll_x = 0;
        sprite_en = 4'b0101;
        sprite_x[0*CW +: CW] = 10'd100; sprite_y[0*CW +: CW] = 10'd100;
        sprite_x[2*CW +: CW] = 10'd100; sprite_y[2*CW +: CW] = 10'd100;
        sprite_rgb[0*12 +: 12] = 12'hF00;
        sprite_rgb[2*12 +: 12] = 12'h00F;
        probe("spr_prio", 100, 100, 1, 12'hF00);
        probe("spr_corner", 141, 141, 0, 12'hF00);
        probe("spr_right_edge", 100, 142, 0, 12'h09F);
        for (int c = 90; c < 150; c++) cyc(1, 0, 141 + (c % 2), c);
        sprite_en = 4'b0100;
        probe("spr0_disabled", 100, 100, 1, 12'h00F);

        // Input changes without frame_start are ignored until the next frame
        sprite_en = 4'b0101;
        probe("relatch", 100, 100, 1, 12'hF00);
        sprite_x[0*CW +: CW] = 10'd500;
        scroll_x = 10'd1000;
        probe("no_latch_spr", 100, 100, 0, 12'hF00);
        probe("no_latch_scroll", 0, 23, 0, 12'h0F2);
        for (int c = 95; c < 110; c++) cyc(1, 0, 100, c);
        probe("latch_scroll", 0, 23, 1, 12'h843);
        probe("latch_spr", 100, 100, 0, 12'h00F);

        // Palette write lands the cycle after pal_we
        scroll_x = 0;
        probe("pal_old", 64, 200, 1, 12'h0F2);
        for (int c = 0; c < 16; c++) begin
            cyc(1, 0, 64, c);
            if (c == 6) begin
                pal_we = 1; pal_addr = 4'd3; pal_data = 12'h123;
            end
        end
        probe("pal_new", 64, 200, 0, 12'h123);
        cyc(0, 0, 0, 0);
        pal_we = 1; pal_addr = 4'd0; pal_data = 12'h5A5;
        probe("oob_row480", 480, 10, 0, 12'h5A5);

        // One-cycle reset mid-line; a palette write during reset is dropped
        for (int c = 0; c < 12; c++) begin
            cyc(1, 0, 64, c);
            if (c == 5) begin
                reset = 1; pal_we = 1; pal_addr = 4'd5; pal_data = 12'hFFF;
            end
        end
        probe("rst_spr_off", 100, 100, 0, 12'h09F);
        probe("rst_pal3", 64, 200, 0, 12'h0F2);
        probe("rst_pal5", 192, 256, 0, 12'h000);

        repeat (4) cyc(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
